// File: rtl/axi4_rd_fifo_ctrl_pkg.sv
// Shared types and helpers for the AXI4 read-path FIFO issue controller.
// Also serves the optional AXI4_RD_FIFO_CTRL_PERF_EN counters (sat_inc32).
package axi4_rd_fifo_ctrl_pkg;

    localparam int DEFAULT_LEN_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Burst length in beats; one extra bit so arlen at full scale cannot wrap.
    function automatic logic [32:0] beats_of(input logic [31:0] len);
        return {1'b0, len} + 33'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
        logic [31:0] result;
        if (en && (value != 32'hFFFF_FFFF)) begin
            result = value + 32'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi4_rd_credit_cnt.sv
// R FIFO credit accounting: beats occupied, beats reserved by granted bursts,
// the resulting free space, and the sticky credit_err flag.
module axi4_rd_credit_cnt
    import axi4_rd_fifo_ctrl_pkg::*;
#(
    parameter int R_DEPTH = 512,
    parameter int CNT_W   = $clog2(R_DEPTH + 1)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             grant,
    input  logic [CNT_W-1:0] grant_beats,
    input  logic             r_wr_en,
    input  logic             r_rd_en,
    output logic [CNT_W-1:0] r_free,
    output logic             credit_err
);

    localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(R_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(R_DEPTH);

    logic [CNT_W-1:0] occupied_r;
    logic [CNT_W-1:0] reserved_r;
    logic             credit_err_r;
    logic [CNT_W:0]   res_sum_s;
    logic [CNT_W:0]   used_s;
    logic [CNT_W-1:0] occupied_nxt_s;
    logic [CNT_W-1:0] reserved_nxt_s;

    // Next-state credit arithmetic; grant and write land in the same cycle as a net change.
    always_comb begin
        res_sum_s = {1'b0, reserved_r} + (grant ? {1'b0, grant_beats} : {(CNT_W + 1){1'b0}});
        if (r_wr_en) begin
            if (res_sum_s == {(CNT_W + 1){1'b0}}) begin
                reserved_nxt_s = {CNT_W{1'b0}};
            end else begin
                reserved_nxt_s = CNT_W'(res_sum_s - {{CNT_W{1'b0}}, 1'b1});
            end
        end else begin
            reserved_nxt_s = CNT_W'(res_sum_s);
        end

        if (r_wr_en && !r_rd_en) begin
            if (occupied_r != DEPTH_C) begin
                occupied_nxt_s = occupied_r + {{(CNT_W - 1){1'b0}}, 1'b1};
            end else begin
                occupied_nxt_s = occupied_r;
            end
        end else if (r_rd_en && !r_wr_en) begin
            if (occupied_r != {CNT_W{1'b0}}) begin
                occupied_nxt_s = occupied_r - {{(CNT_W - 1){1'b0}}, 1'b1};
            end else begin
                occupied_nxt_s = occupied_r;
            end
        end else begin
            occupied_nxt_s = occupied_r;
        end
    end

    // Free space clamps at zero so spurious writes can never make it wrap.
    always_comb begin
        used_s = {1'b0, occupied_r} + {1'b0, reserved_r};
        if (used_s >= DEPTH_W) begin
            r_free = {CNT_W{1'b0}};
        end else begin
            r_free = CNT_W'(DEPTH_W - used_s);
        end
    end

    // Credit counters and sticky error flag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            occupied_r   <= {CNT_W{1'b0}};
            reserved_r   <= {CNT_W{1'b0}};
            credit_err_r <= 1'b0;
        end else begin
            occupied_r   <= occupied_nxt_s;
            reserved_r   <= reserved_nxt_s;
            credit_err_r <= credit_err_r | (r_wr_en && (reserved_r == {CNT_W{1'b0}}));
        end
    end

    assign credit_err = credit_err_r;

endmodule

// File: rtl/axi4_rd_fifo_ctrl.sv
// AXI4 read issue controller: releases AR bursts only with R FIFO room reserved.
// Optional stall/burst counters are enabled by AXI4_RD_FIFO_CTRL_PERF_EN.
module axi4_rd_fifo_ctrl
    import axi4_rd_fifo_ctrl_pkg::*;
#(
    parameter int R_DEPTH         = 512,
    parameter int MAX_OUTSTANDING = 8,
    parameter int LEN_W           = DEFAULT_LEN_W,
    parameter int CNT_W           = $clog2(R_DEPTH + 1),
    parameter int OST_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             ar_rd_empty,
    input  logic [LEN_W-1:0] ar_len,
    output logic             ar_rd_en,
    output logic             m_arvalid,
    input  logic             m_arready,
    input  logic             r_wr_en,
    input  logic             r_last,
    input  logic             r_rd_en,
    output logic [CNT_W-1:0] r_free,
    output logic [OST_W-1:0] outstanding,
    output logic             len_err,
    output logic             credit_err
`ifdef AXI4_RD_FIFO_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_credit_cnt,
    output logic [31:0]      stall_ost_cnt,
    output logic [31:0]      burst_cnt
`endif
);

    localparam int BEATS_W = ((LEN_W > CNT_W) ? LEN_W : CNT_W) + 1;

    state_t             state_r;
    logic               m_arvalid_r;
    logic               len_err_r;
    logic [OST_W-1:0]   outstanding_r;
    logic [OST_W-1:0]   ost_nxt_s;
    logic [BEATS_W-1:0] beats_s;
    logic               head_s;
    logic               fit_s;
    logic               ost_ok_s;
    logic               too_long_s;
    logic               grant_s;
    logic               ost_dec_s;

    assign beats_s    = BEATS_W'(beats_of(32'(ar_len)));
    assign head_s     = (state_r == IDLE) && !ar_rd_empty && !len_err_r;
    assign fit_s      = beats_s <= BEATS_W'(r_free);
    assign ost_ok_s   = outstanding_r < OST_W'(MAX_OUTSTANDING);
    assign too_long_s = (state_r == IDLE) && !ar_rd_empty && (beats_s > BEATS_W'(R_DEPTH));
    assign grant_s    = head_s && fit_s && ost_ok_s && !too_long_s;
    assign ost_dec_s  = r_wr_en && r_last;

    assign ar_rd_en    = m_arvalid_r && m_arready;
    assign m_arvalid   = m_arvalid_r;
    assign outstanding = outstanding_r;
    assign len_err     = len_err_r;

    // Outstanding-burst count: grant and completion in one cycle cancel out.
    always_comb begin
        if (grant_s && !ost_dec_s) begin
            ost_nxt_s = outstanding_r + {{(OST_W - 1){1'b0}}, 1'b1};
        end else if (!grant_s && ost_dec_s && (outstanding_r != {OST_W{1'b0}})) begin
            ost_nxt_s = outstanding_r - {{(OST_W - 1){1'b0}}, 1'b1};
        end else begin
            ost_nxt_s = outstanding_r;
        end
    end

    // Issue FSM with registered AR valid; an oversized head locks it in IDLE.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r       <= IDLE;
            m_arvalid_r   <= 1'b0;
            len_err_r     <= 1'b0;
            outstanding_r <= {OST_W{1'b0}};
        end else begin
            outstanding_r <= ost_nxt_s;
            len_err_r     <= len_err_r | too_long_s;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        state_r     <= ISSUE;
                        m_arvalid_r <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        m_arvalid_r <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (m_arready) begin
                        state_r     <= IDLE;
                        m_arvalid_r <= 1'b0;
                    end else begin
                        state_r     <= ISSUE;
                        m_arvalid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    m_arvalid_r <= 1'b0;
                end
            endcase
        end
    end

    axi4_rd_credit_cnt #(
        .R_DEPTH (R_DEPTH),
        .CNT_W   (CNT_W)
    ) u_credit (
        .aclk        (aclk),
        .areset      (areset),
        .grant       (grant_s),
        .grant_beats (CNT_W'(beats_s)),
        .r_wr_en     (r_wr_en),
        .r_rd_en     (r_rd_en),
        .r_free      (r_free),
        .credit_err  (credit_err)
    );

`ifdef AXI4_RD_FIFO_CTRL_PERF_EN
    logic stall_credit_s;
    logic stall_ost_s;

    assign stall_credit_s = head_s && !too_long_s && !fit_s && ost_ok_s;
    assign stall_ost_s    = head_s && !too_long_s && fit_s && !ost_ok_s;

    // Saturating performance counters.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stall_credit_cnt <= 32'd0;
            stall_ost_cnt    <= 32'd0;
            burst_cnt        <= 32'd0;
        end else begin
            stall_credit_cnt <= sat_inc32(stall_credit_cnt, stall_credit_s);
            stall_ost_cnt    <= sat_inc32(stall_ost_cnt, stall_ost_s);
            burst_cnt        <= sat_inc32(burst_cnt, ar_rd_en);
        end
    end
`endif

endmodule
